// File: rtl/fifo_arb_if.sv
// Client-side bus of the line-buffer RAM arbiter: one read port and one posted-write port.
interface fifo_arb_if #(
    parameter int DW = 8,
    parameter int AW = 13
);
    // Handshake: a request is consumed in any cycle where req and ack are both high;
    // the requester holds req/addr/data stable until it sees ack. rd_valid is a
    // one-cycle strobe that qualifies rd_data and has no back-pressure.
    logic          rd_req;
    logic          rd_ack;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_req;
    logic          wr_ack;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data,
        input  rd_ack, rd_data, rd_valid, wr_ack
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
        output rd_ack, rd_data, rd_valid, wr_ack
    );
endinterface

// File: rtl/fifo_arb.sv
// Single-port SRAM arbiter: reads have priority, writes are posted into a small circular
// buffer with bounded starvation. Optional read-after-write bypass: FIFO_ARB_RAW_BYPASS_EN.
module fifo_arb #(
    parameter int DW         = 8,
    parameter int AW         = 13,
    parameter int WB_DEPTH   = 2,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                        clk,
    input  logic                        rst_x,
    fifo_arb_if.slave                   bus,
    output logic                        ram_ce,
    output logic                        ram_we,
    output logic [AW-1:0]               ram_addr,
    output logic [DW-1:0]               ram_wdata,
    input  logic [DW-1:0]               ram_rdata,
    output logic [$clog2(WB_DEPTH):0]   wb_level,
    output logic                        wb_full
);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int LW = PW + 1;

    logic [AW-1:0]     wb_addr [WB_DEPTH];
    logic [DW-1:0]     wb_dat  [WB_DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [LW-1:0]     level;
    logic [3:0]        starve_cnt;
    logic [RD_LAT-1:0] vld_pipe;
    logic              wb_nonempty;
    logic              wsel;
    logic              wr_ack;
    logic              rd_ack;
    logic [DW-1:0]     sample_data;

    assign wb_nonempty = (level != '0);
    assign wb_full     = (level == LW'(WB_DEPTH));
    assign wb_level    = level;

    // Full is taken from the registered level, so a same-cycle drain never frees a slot early.
    assign wr_ack = bus.wr_req & ~wb_full;
    assign wsel   = wb_nonempty & (~bus.rd_req | (starve_cnt == 4'(STARVE_MAX)));
    assign rd_ack = bus.rd_req & ~wsel;

    assign bus.wr_ack = wr_ack;
    assign bus.rd_ack = rd_ack;
    assign ram_ce     = rd_ack | wsel;
    assign ram_we     = wsel;
    assign ram_addr   = wsel ? wb_addr[head] : bus.rd_addr;
    assign ram_wdata  = wb_dat[head];

    // Buffer storage needs no reset: only entries between head and tail are ever consumed.
    always_ff @(posedge clk) begin
        if (wr_ack) begin
            wb_addr[tail] <= bus.wr_addr;
            wb_dat[tail]  <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            head         <= '0;
            tail         <= '0;
            level        <= '0;
            starve_cnt   <= '0;
            vld_pipe     <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
        end else begin
            if (wr_ack) tail <= tail + 1'b1;
            if (wsel)   head <= head + 1'b1;
            level <= level + LW'(wr_ack) - LW'(wsel);

            if (wsel || !wb_nonempty)
                starve_cnt <= '0;
            else if (rd_ack && starve_cnt != 4'(STARVE_MAX))
                starve_cnt <= starve_cnt + 4'd1;

            vld_pipe[0] <= rd_ack;
            for (int i = 1; i < RD_LAT; i++)
                vld_pipe[i] <= vld_pipe[i-1];

            bus.rd_valid <= vld_pipe[RD_LAT-1];
            if (vld_pipe[RD_LAT-1])
                bus.rd_data <= sample_data;
        end
    end

`ifdef FIFO_ARB_RAW_BYPASS_EN
    logic              byp_hit;
    logic [DW-1:0]     byp_data;
    logic [RD_LAT-1:0] hit_pipe;
    logic [DW-1:0]     data_pipe [RD_LAT];

    // Scan oldest to newest so the newest matching posted write wins.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if ((LW'(i) < level) && (wb_addr[head + PW'(i)] == bus.rd_addr)) begin
                byp_hit  = 1'b1;
                byp_data = wb_dat[head + PW'(i)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            hit_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++)
                data_pipe[i] <= '0;
        end else begin
            hit_pipe[0]  <= rd_ack & byp_hit;
            data_pipe[0] <= byp_data;
            for (int i = 1; i < RD_LAT; i++) begin
                hit_pipe[i]  <= hit_pipe[i-1];
                data_pipe[i] <= data_pipe[i-1];
            end
        end
    end

    assign sample_data = hit_pipe[RD_LAT-1] ? data_pipe[RD_LAT-1] : ram_rdata;
`else
    assign sample_data = ram_rdata;
`endif
endmodule

// File: tb/tb_fifo_arb.sv
// Directed bench for fifo_arb with a behavioural single-port RAM and read/write scoreboards.
module tb_fifo_arb;
    localparam int DW         = 8;
    localparam int AW         = 13;
    localparam int WB_DEPTH   = 2;
    localparam int RD_LAT     = 1;
    localparam int STARVE_MAX = 4;
    localparam int LW         = 2;

    logic          clk   = 1'b0;
    logic          rst_x = 1'b0;
    logic          ram_ce;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic [LW-1:0] wb_level;
    logic          wb_full;

    int n_chk = 0;
    int n_err = 0;
    int rdv_cnt = 0;
    int we_cnt = 0;

    logic [DW-1:0]    exp_q[$];
    logic [AW+DW-1:0] wexp_q[$];

    bit [DW-1:0] mem [1 << AW];
    bit          written [1 << AW];

    fifo_arb_if #(.DW(DW), .AW(AW)) bus();

    fifo_arb #(
        .DW(DW), .AW(AW), .WB_DEPTH(WB_DEPTH), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst_x     (rst_x),
        .bus       (bus),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .wb_level  (wb_level),
        .wb_full   (wb_full)
    );

    always #5 clk = ~clk;

    // ---------------- RAM model (1-cycle synchronous read) ----------------
    function automatic logic [DW-1:0] preload(input logic [AW-1:0] a);
        if (a == 13'h1270)       return 8'h5A;
        if (a[12:8] == 5'h01)    return 8'(a[7:0] * 7 + 1);
        return 8'h00;
    endfunction

    function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
        return written[a] ? mem[a] : preload(a);
    endfunction

    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) begin
                mem[ram_addr]     <= ram_wdata;
                written[ram_addr] <= 1'b1;
            end else begin
                ram_rdata <= ram_val(ram_addr);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = ram_val(a);
`ifdef FIFO_ARB_RAW_BYPASS_EN
        foreach (wexp_q[i])
            if (wexp_q[i][AW+DW-1:DW] == a) v = wexp_q[i][DW-1:0];
`endif
        return v;
    endfunction

    // Scoreboard monitor: RAM writes must match ack order; read data must match the model.
    always @(negedge clk) begin
        if (rst_x) begin
            if (ram_ce && ram_we) begin
                we_cnt++;
                chk("ram_wr_pending", 32'(wexp_q.size() > 0), 32'd1);
                if (wexp_q.size() > 0)
                    chk("ram_wr_order", 32'({ram_addr, ram_wdata}), 32'(wexp_q.pop_front()));
            end
            if (bus.rd_valid) begin
                rdv_cnt++;
                chk("rd_valid_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0)
                    chk("rd_data_sb", 32'(bus.rd_data), 32'(exp_q.pop_front()));
            end
            if (bus.rd_ack) exp_q.push_back(exp_read(bus.rd_addr));
            if (bus.wr_ack) wexp_q.push_back({bus.wr_addr, bus.wr_data});
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic rq, input logic [AW-1:0] ra,
                         input logic wq, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        @(posedge clk);
        #1;
        bus.rd_req  = rq;
        bus.rd_addr = ra;
        bus.wr_req  = wq;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, '0);
    endtask

    logic [7:0] t4_wack;
    int         widx;
    logic [DW-1:0] byp_exp;

    initial begin
        bus.rd_req  = 1'b0;
        bus.rd_addr = '0;
        bus.wr_req  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        // Reset state
        @(negedge clk);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_rd_data",  32'(bus.rd_data),  32'd0);
        chk("rst_wb_level", 32'(wb_level),     32'd0);
        chk("rst_wb_full",  32'(wb_full),      32'd0);
        chk("rst_ram_ce",   32'(ram_ce),       32'd0);
        bus.rd_req = 1'b1;
        bus.wr_req = 1'b1;
        #1;
        chk("rst_rd_ack", 32'(bus.rd_ack), 32'd1);
        chk("rst_wr_ack", 32'(bus.wr_ack), 32'd1);
        chk("rst_ram_ce_rq", 32'(ram_ce),  32'd1);
        chk("rst_ram_we", 32'(ram_we),     32'd0);
        @(posedge clk);
        #1;
        rst_x      = 1'b1;
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        @(negedge clk);

        // Three posted writes with no reads: each drains the cycle after it is queued
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, '0, 1'b1, AW'(13'h10 + k), DW'(8'hA0 + k));
            chk("t1_wr_ack", 32'(bus.wr_ack), 32'd1);
            chk("t1_level",  32'(wb_level), (k == 0) ? 32'd0 : 32'd1);
            chk("t1_ram_we", 32'(ram_we),   (k == 0) ? 32'd0 : 32'd1);
            if (k > 0) chk("t1_ram_addr", 32'(ram_addr), 32'(13'h10 + k - 1));
        end
        drive(1'b0, '0, 1'b0, '0, '0);
        chk("t1_last_we",   32'(ram_we),    32'd1);
        chk("t1_last_addr", 32'(ram_addr),  32'h12);
        chk("t1_last_data", 32'(ram_wdata), 32'hA2);
        drive(1'b0, '0, 1'b0, '0, '0);
        chk("t1_level_end", 32'(wb_level), 32'd0);
        chk("t1_we_end",    32'(ram_we),   32'd0);

        // Single read, latency RD_LAT+1
        drive(1'b1, 13'h1270, 1'b0, '0, '0);
        chk("t2_rd_ack", 32'(bus.rd_ack), 32'd1);
        drive(1'b0, '0, 1'b0, '0, '0);
        chk("t2_valid_c1", 32'(bus.rd_valid), 32'd0);
        drive(1'b0, '0, 1'b0, '0, '0);
        chk("t2_valid_c2", 32'(bus.rd_valid), 32'd1);
        chk("t2_data_c2",  32'(bus.rd_data),  32'h5A);
        drive(1'b0, '0, 1'b0, '0, '0);
        chk("t2_valid_c3", 32'(bus.rd_valid), 32'd0);
        chk("t2_data_hold", 32'(bus.rd_data), 32'h5A);

        // Starvation bound: one pending write under 20 cycles of reads
        drive(1'b0, '0, 1'b1, 13'h200, 8'h77);
        chk("t3_wr_ack", 32'(bus.wr_ack), 32'd1);
        rdv_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, AW'(13'h100 + i), 1'b0, '0, '0);
            chk("t3_rd_ack", 32'(bus.rd_ack), (i == STARVE_MAX) ? 32'd0 : 32'd1);
            chk("t3_ram_we", 32'(ram_we),     (i == STARVE_MAX) ? 32'd1 : 32'd0);
            if (i == STARVE_MAX) chk("t3_ram_addr", 32'(ram_addr), 32'h200);
        end
        idle(3);
        chk("t3_rd_valid_cnt", 32'(rdv_cnt), 32'd19);

        // Full buffer under held reads: wr_ack returns only after the forced drain
        t4_wack = 8'b0100_0011;
        widx = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, AW'(13'h120 + k), 1'b1, AW'(13'h300 + widx), DW'(8'hC0 + widx));
            chk("t4_wr_ack", 32'(bus.wr_ack), 32'(t4_wack[k]));
            chk("t4_ram_we", 32'(ram_we), (k == 5) ? 32'd1 : 32'd0);
            if (bus.wr_ack) widx++;
        end
        idle(3);
        chk("t4_widx",  32'(widx),     32'd3);
        chk("t4_level", 32'(wb_level), 32'd0);

        // Reset mid-operation discards posted writes and in-flight reads
        drive(1'b1, 13'h101, 1'b1, 13'h400, 8'h11);
        chk("t5_rd_ack0", 32'(bus.rd_ack), 32'd1);
        chk("t5_wr_ack0", 32'(bus.wr_ack), 32'd1);
        drive(1'b1, 13'h102, 1'b1, 13'h401, 8'h12);
        chk("t5_rd_ack1", 32'(bus.rd_ack), 32'd1);
        chk("t5_wr_ack1", 32'(bus.wr_ack), 32'd1);
        @(posedge clk);
        #1;
        rst_x      = 1'b0;
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        exp_q.delete();
        wexp_q.delete();
        we_cnt  = 0;
        rdv_cnt = 0;
        @(negedge clk);
        chk("t5_rst_level", 32'(wb_level),     32'd0);
        chk("t5_rst_valid", 32'(bus.rd_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_x = 1'b1;
        @(negedge clk);
        idle(5);
        chk("t5_no_valid", 32'(rdv_cnt),  32'd0);
        chk("t5_no_write", 32'(we_cnt),   32'd0);
        chk("t5_level",    32'(wb_level), 32'd0);

        // Read of an address with a write still posted
`ifdef FIFO_ARB_RAW_BYPASS_EN
        byp_exp = 8'h33;
`else
        byp_exp = 8'h00;
`endif
        drive(1'b1, 13'h500, 1'b1, 13'h040, 8'h33);
        chk("t6_rd_ack0", 32'(bus.rd_ack), 32'd1);
        chk("t6_wr_ack",  32'(bus.wr_ack), 32'd1);
        drive(1'b1, 13'h040, 1'b0, '0, '0);
        chk("t6_rd_ack1", 32'(bus.rd_ack), 32'd1);
        drive(1'b0, '0, 1'b0, '0, '0);
        chk("t6_drain_we", 32'(ram_we), 32'd1);
        drive(1'b0, '0, 1'b0, '0, '0);
        chk("t6_valid",   32'(bus.rd_valid), 32'd1);
        chk("t6_rd_data", 32'(bus.rd_data),  32'(byp_exp));

        idle(4);
        chk("end_rd_queue", 32'(exp_q.size()),  32'd0);
        chk("end_wr_queue", 32'(wexp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
